// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one sequential divider
// between N_REQ requesters and returns tagged responses on a valid/ready port.
module div_arbiter #(
    parameter  int D_WIDTH = 8,
    parameter  int N_REQ   = 4,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ*D_WIDTH-1:0] i_req_dividend,
    input  logic [N_REQ*D_WIDTH-1:0] i_req_divisor,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [D_WIDTH-1:0]       o_rsp_quotient,
    output logic [D_WIDTH-1:0]       o_rsp_remainder,
    output logic                     o_rsp_dbz,
    output logic                     o_rsp_err,
    output logic                     o_div_start,
    output logic [D_WIDTH-1:0]       o_div_dividend,
    output logic [D_WIDTH-1:0]       o_div_divisor,
    input  logic                     i_div_done,
    input  logic [D_WIDTH-1:0]       i_div_quotient,
    input  logic [D_WIDTH-1:0]       i_div_remainder,
    output logic                     o_busy
);

    // The divider should finish in about D_WIDTH cycles; twice that means it is stuck.
    localparam int WCNT_MAX = 2 * D_WIDTH;
    localparam int WCNT_W   = $clog2(WCNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [D_WIDTH-1:0]  dividend_q, dividend_d;
    logic [D_WIDTH-1:0]  divisor_q, divisor_d;
    logic [D_WIDTH-1:0]  quot_q, quot_d;
    logic [D_WIDTH-1:0]  rem_q, rem_d;
    logic                dbz_q, dbz_d;
    logic                err_q, err_d;
    logic [WCNT_W-1:0]   waitCnt_q, waitCnt_d;

    logic                grantValid;
    logic [ID_W-1:0]     grantIdx;
    logic [ID_W:0]       candIdx;
    logic [ID_W-1:0]     nextPtr;

    // Round-robin grant: first valid requester at or above rrPtr_q, wrapping around.
    always_comb begin
        grantValid  = 1'b0;
        grantIdx    = '0;
        candIdx     = '0;
        o_req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            candIdx = {1'b0, rrPtr_q} + (ID_W+1)'(i);
            if (candIdx >= (ID_W+1)'(N_REQ)) begin
                candIdx = candIdx - (ID_W+1)'(N_REQ);
            end
            if (!grantValid && i_req_valid[candIdx[ID_W-1:0]]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx[ID_W-1:0];
            end
        end
        if (i_rstn && (state_q == IDLE) && grantValid) begin
            o_req_ready[grantIdx] = 1'b1;
        end
    end

    // Pointer value after the current response: the requester just above the one served.
    always_comb begin
        nextPtr = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    end

    // Next-state logic: accept, launch the divider, wait for done or timeout, hand back.
    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        err_d      = err_q;
        waitCnt_d  = waitCnt_q;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    id_d       = grantIdx;
                    dividend_d = i_req_dividend[grantIdx*D_WIDTH +: D_WIDTH];
                    divisor_d  = i_req_divisor[grantIdx*D_WIDTH +: D_WIDTH];
                    err_d      = 1'b0;
                    if (i_req_divisor[grantIdx*D_WIDTH +: D_WIDTH] == '0) begin
                        quot_d  = '1;
                        rem_d   = i_req_dividend[grantIdx*D_WIDTH +: D_WIDTH];
                        dbz_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = START;
                    end
                end
            end
            START: begin
                waitCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (i_div_done) begin
                    quot_d  = i_div_quotient;
                    rem_d   = i_div_remainder;
                    state_d = RESP;
                end else if (waitCnt_q == WCNT_W'(WCNT_MAX)) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rrPtr_d = nextPtr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            err_q      <= 1'b0;
            waitCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            id_q       <= id_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            err_q      <= err_d;
            waitCnt_q  <= waitCnt_d;
        end
    end

    // Output drive straight from state and latched registers.
    always_comb begin
        o_rsp_valid     = (state_q == RESP);
        o_rsp_id        = id_q;
        o_rsp_quotient  = quot_q;
        o_rsp_remainder = rem_q;
        o_rsp_dbz       = dbz_q;
        o_rsp_err       = err_q;
        o_div_start     = (state_q == START);
        o_div_dividend  = dividend_q;
        o_div_divisor   = divisor_q;
        o_busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: drives div_arbiter with directed and random requests,
// emulates the shared divider, and checks every cycle against a transaction model.
module tb_div_arbiter;

    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  q;
        logic [DW-1:0]  r;
        logic           dbz;
        logic           err;
        logic           startSeen;
        logic [31:0]    lat;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    reqValid = '0;
    logic [DW-1:0]   reqA [N];
    logic [DW-1:0]   reqB [N];
    logic [N*DW-1:0] pkA, pkB;
    logic            rspReady = 1'b0;
    logic            divHang = 1'b0;

    logic [N-1:0]    o_req_ready;
    logic            o_rsp_valid, o_rsp_dbz, o_rsp_err, o_div_start, o_busy;
    logic [IDW-1:0]  o_rsp_id;
    logic [DW-1:0]   o_rsp_quotient, o_rsp_remainder, o_div_dividend, o_div_divisor;
    logic            divDone;
    logic [DW-1:0]   divQ, divR;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    rsp_t rspQ[$];
    int   grantLog[$];
    int   accCount[N] = '{default: 0};
    int   accSeen[N]  = '{default: 0};

    div_arbiter #(.D_WIDTH(DW), .N_REQ(N)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(reqValid), .o_req_ready(o_req_ready),
        .i_req_dividend(pkA), .i_req_divisor(pkB),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rspReady),
        .o_rsp_id(o_rsp_id), .o_rsp_quotient(o_rsp_quotient),
        .o_rsp_remainder(o_rsp_remainder), .o_rsp_dbz(o_rsp_dbz), .o_rsp_err(o_rsp_err),
        .o_div_start(o_div_start), .o_div_dividend(o_div_dividend),
        .o_div_divisor(o_div_divisor), .i_div_done(divDone),
        .i_div_quotient(divQ), .i_div_remainder(divR), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            pkA[k*DW +: DW] = reqA[k];
            pkB[k*DW +: DW] = reqB[k];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Divider emulation: result appears D_WIDTH+1 cycles after start, done then
    // lingers for three more cycles with scrambled data, as a free-running divider would.
    logic [DW-1:0] sA, sB;
    logic          sBusy;
    int            sCnt, sDoneCnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sBusy <= 0; sCnt <= 0; sDoneCnt <= 0; divDone <= 0; divQ <= 0; divR <= 0;
            sA <= 0; sB <= 0;
        end else if (o_div_start) begin
            sA <= o_div_dividend; sB <= o_div_divisor; sBusy <= 1; sCnt <= 0;
            divDone <= 0; sDoneCnt <= 0;
        end else if (sBusy) begin
            if (sCnt == DW - 1) begin
                sBusy <= 0;
                if (!divHang) begin
                    divDone <= 1; divQ <= sA / sB; divR <= sA % sB; sDoneCnt <= 3;
                end
            end else begin
                sCnt <= sCnt + 1;
            end
        end else if (sDoneCnt != 0) begin
            sDoneCnt <= sDoneCnt - 1;
            divQ <= ~divQ ^ 8'h5A;
            divR <= divR + 8'd1;
        end else begin
            divDone <= 0;
        end
    end

    // Transaction model: one operation in flight, timing taken from the accept cycle.
    bit            mActive = 0;
    int            mPtr = 0, mAcc, mId, mLat, mFirst, since, g;
    bit            mDbz, mErr, mStart, found;
    logic [DW-1:0] mA, mB, expQ, expR;
    logic [N-1:0]  expReady;
    rsp_t          mRec;
    always @(negedge clk) begin
        if (!rstn) begin
            mActive = 0; mPtr = 0;
            checkOutput("rst_req_ready", 32'(o_req_ready), 0);
            checkOutput("rst_busy", 32'(o_busy), 0);
            checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 0);
            checkOutput("rst_div_start", 32'(o_div_start), 0);
            checkOutput("rst_rsp_fields",
                32'({o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_dbz, o_rsp_err}), 0);
            checkOutput("rst_div_operands", 32'({o_div_dividend, o_div_divisor}), 0);
        end else if (!mActive) begin
            expReady = '0; found = 0; g = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && reqValid[(mPtr + i) % N]) begin
                    found = 1; g = (mPtr + i) % N;
                end
            end
            if (found) expReady[g] = 1'b1;
            checkOutput("idle_req_ready", 32'(o_req_ready), 32'(expReady));
            checkOutput("idle_busy", 32'(o_busy), 0);
            checkOutput("idle_rsp_valid", 32'(o_rsp_valid), 0);
            checkOutput("idle_div_start", 32'(o_div_start), 0);
            if (found) begin
                mActive = 1; mAcc = cyc; mId = g; mA = reqA[g]; mB = reqB[g];
                mDbz = (mB == 0); mErr = !mDbz && divHang;
                mLat = mDbz ? 1 : (mErr ? 2*DW + 3 : DW + 3);
                mStart = 0; mFirst = -1;
                grantLog.push_back(g);
                accCount[g]++;
            end
        end else begin
            since = cyc - mAcc;
            checkOutput("op_req_ready", 32'(o_req_ready), 0);
            checkOutput("op_busy", 32'(o_busy), 1);
            checkOutput("op_div_start", 32'(o_div_start), 32'(!mDbz && since == 1));
            if (o_div_start) mStart = 1;
            if (!mDbz && since == 1) checkOutput("div_dividend", 32'(o_div_dividend), 32'(mA));
            if (!mDbz) checkOutput("div_divisor_stable", 32'(o_div_divisor), 32'(mB));
            checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(since >= mLat));
            if (o_rsp_valid && mFirst < 0) mFirst = since;
            if (since >= mLat) begin
                expQ = mDbz ? 8'hFF : (mErr ? 8'h00 : mA / mB);
                expR = mDbz ? mA : (mErr ? 8'h00 : mA % mB);
                checkOutput("rsp_id", 32'(o_rsp_id), 32'(mId));
                checkOutput("rsp_quotient", 32'(o_rsp_quotient), 32'(expQ));
                checkOutput("rsp_remainder", 32'(o_rsp_remainder), 32'(expR));
                checkOutput("rsp_dbz", 32'(o_rsp_dbz), 32'(mDbz));
                checkOutput("rsp_err", 32'(o_rsp_err), 32'(mErr));
                if (rspReady) begin
                    mRec.id = o_rsp_id; mRec.q = o_rsp_quotient; mRec.r = o_rsp_remainder;
                    mRec.dbz = o_rsp_dbz; mRec.err = o_rsp_err; mRec.startSeen = mStart;
                    mRec.lat = 32'(mFirst);
                    rspQ.push_back(mRec);
                    mActive = 0;
                    mPtr = (mId + 1) % N;
                end
            end
        end
    end

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dropAccepted();
        for (int k = 0; k < N; k++) begin
            if (accCount[k] != accSeen[k]) begin
                accSeen[k] = accCount[k];
                reqValid[k] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output rsp_t rec);
        int n0;
        int budget;
        n0 = rspQ.size();
        reqA[id] = a; reqB[id] = b; reqValid[id] = 1'b1; rspReady = 1'b1;
        budget = 0;
        while (rspQ.size() == n0 && budget < 100) begin
            waitCycle(); dropAccepted(); budget++;
        end
        if (rspQ.size() == n0) begin
            checkOutput("rsp_timeout", 0, 1);
            rec = '0;
        end else begin
            rec = rspQ[$];
        end
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        rspReady = 1'b1;
        while ((o_busy || reqValid != '0) && budget < 300) begin
            waitCycle(); dropAccepted(); budget++;
        end
        checkOutput("drain_idle", 32'(o_busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rsp_t rec;
        int   n0, g0, a0, budget;
        for (int k = 0; k < N; k++) begin reqA[k] = '0; reqB[k] = '0; end
        rstn = 1'b0; rspReady = 1'b1;
        repeat (3) waitCycle();
        checkOutput("reset_busy", 32'(o_busy), 0);
        checkOutput("reset_div_start", 32'(o_div_start), 0);
        rstn = 1'b1;
        waitCycle();

        applyStimulus(2, 8'd100, 8'd7, rec);
        checkOutput("basic_id", 32'(rec.id), 2);
        checkOutput("basic_q", 32'(rec.q), 14);
        checkOutput("basic_r", 32'(rec.r), 2);
        checkOutput("basic_flags", 32'({rec.dbz, rec.err}), 0);
        checkOutput("basic_latency", rec.lat, 11);

        applyStimulus(0, 8'd55, 8'd0, rec);
        checkOutput("dbz_q", 32'(rec.q), 32'hFF);
        checkOutput("dbz_r", 32'(rec.r), 55);
        checkOutput("dbz_flag", 32'(rec.dbz), 1);
        checkOutput("dbz_no_start", 32'(rec.startSeen), 0);
        checkOutput("dbz_latency", rec.lat, 1);

        applyStimulus(1, 8'd255, 8'd1, rec);
        checkOutput("edge_255_1", 32'({rec.q, rec.r}), 32'hFF00);
        applyStimulus(3, 8'd3, 8'd200, rec);
        checkOutput("edge_3_200", 32'({rec.q, rec.r}), 32'h0003);
        applyStimulus(0, 8'd200, 8'd200, rec);
        checkOutput("edge_200_200", 32'({rec.q, rec.r}), 32'h0100);

        // Backpressure: response held five cycles, competing requester waits.
        rspReady = 1'b0;
        reqA[1] = 8'd20; reqB[1] = 8'd3; reqValid[1] = 1'b1;
        budget = 0;
        while (!o_rsp_valid && budget < 40) begin waitCycle(); dropAccepted(); budget++; end
        checkOutput("bp_reached_resp", 32'(o_rsp_valid), 1);
        reqA[3] = 8'd50; reqB[3] = 8'd5; reqValid[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_fields", 32'({o_rsp_id, o_rsp_quotient, o_rsp_remainder}), 32'h10602);
            checkOutput("bp_hold_ready", 32'(o_req_ready), 0);
            waitCycle();
        end
        rspReady = 1'b1;
        waitCycle();
        checkOutput("bp_resume_ready", 32'(o_req_ready), 32'b1000);
        waitIdle();

        divHang = 1'b1;
        applyStimulus(1, 8'd77, 8'd5, rec);
        checkOutput("timeout_err", 32'(rec.err), 1);
        checkOutput("timeout_qr", 32'({rec.q, rec.r}), 0);
        checkOutput("timeout_latency", rec.lat, 2*DW + 3);
        divHang = 1'b0;

        // Reset while the divider is running.
        a0 = accCount[2];
        reqA[2] = 8'd100; reqB[2] = 8'd7; reqValid[2] = 1'b1;
        budget = 0;
        while (accCount[2] == a0 && budget < 20) begin waitCycle(); budget++; end
        dropAccepted();
        repeat (4) waitCycle();
        checkOutput("rstwait_busy_before", 32'(o_busy), 1);
        rstn = 1'b0;
        #1;
        checkOutput("rstwait_busy", 32'(o_busy), 0);
        checkOutput("rstwait_rsp_valid", 32'(o_rsp_valid), 0);
        checkOutput("rstwait_divisor", 32'(o_div_divisor), 0);
        repeat (2) waitCycle();
        rstn = 1'b1;
        n0 = rspQ.size();
        repeat (20) waitCycle();
        checkOutput("rstwait_no_spurious", 32'(rspQ.size()), 32'(n0));
        applyStimulus(0, 8'd9, 8'd4, rec);
        checkOutput("rstwait_fresh", 32'({rec.q, rec.r}), 32'h0201);

        // Round-robin with every requester holding valid from a fresh pointer.
        rstn = 1'b0;
        repeat (2) waitCycle();
        rstn = 1'b1;
        g0 = grantLog.size(); n0 = rspQ.size();
        reqA[0] = 8'd50;  reqB[0] = 8'd3;
        reqA[1] = 8'd77;  reqB[1] = 8'd9;
        reqA[2] = 8'd200; reqB[2] = 8'd13;
        reqA[3] = 8'd31;  reqB[3] = 8'd31;
        reqValid = '1;
        budget = 0;
        while (rspQ.size() < n0 + 5 && budget < 100) begin waitCycle(); budget++; end
        reqValid = '0;
        for (int k = 0; k < N; k++) accSeen[k] = accCount[k];
        checkOutput("rr_count", 32'(rspQ.size() - n0), 5);
        if (rspQ.size() >= n0 + 5 && grantLog.size() >= g0 + 5) begin
            for (int j = 0; j < 5; j++) begin
                checkOutput("rr_grant_order", 32'(grantLog[g0 + j]), 32'(j % N));
                checkOutput("rr_rsp_id", 32'(rspQ[n0 + j].id), 32'(j % N));
            end
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            waitCycle();
            dropAccepted();
            for (int k = 0; k < N; k++) begin
                if (!reqValid[k] && $urandom_range(0, 3) == 0) begin
                    reqA[k] = DW'($urandom);
                    reqB[k] = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
                    reqValid[k] = 1'b1;
                end
            end
            rspReady = ($urandom_range(0, 9) < 7);
        end
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
